// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer that shares the CSR file write port with CSR instructions.
// Trap entry writes mepc/mcause/mtval, reads mtvec and redirects fetch; MRET reads mepc and redirects.
module trap_sequencer #(
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iExcValid,
    input  logic        iExcIntr,
    input  logic [4:0]  iExcCause,
    input  logic [31:0] iExcPC,
    input  logic [31:0] iExcTval,
    input  logic        iMret,
    input  logic        iCsrReqValid,
    input  logic [11:0] iCsrReqAddr,
    input  logic [31:0] iCsrReqData,
    output logic        oCsrReqReady,
    output logic        oExcAck,
    output logic        oMretAck,
    output logic        oCsrWe,
    output logic [11:0] oCsrWAddr,
    output logic [31:0] oCsrWData,
    output logic [11:0] oCsrRAddr,
    input  logic [31:0] iCsrRData,
    output logic        oStall,
    output logic        oPCRedirect,
    output logic [31:0] oPCTarget
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        RD_VEC,
        RD_EPC,
        REDIR
    } state_t;

    state_t      state_q, state_d;
    logic        intr_q, intr_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] target_q, target_d;

    logic [31:0] vecBase;
    logic [1:0]  vecMode;
    logic [31:0] vecOffset;

    // The PC is word-aligned when latched, so the low two bits never matter.
    logic        unusedPcBits;
    assign unusedPcBits = ^iExcPC[1:0];

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q  <= IDLE;
            intr_q   <= 1'b0;
            cause_q  <= '0;
            pc_q     <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            intr_q   <= intr_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        intr_d       = intr_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        tval_d       = tval_q;
        target_d     = target_q;
        oCsrReqReady = 1'b0;
        oExcAck      = 1'b0;
        oMretAck     = 1'b0;
        oCsrWe       = 1'b0;
        oCsrWAddr    = '0;
        oCsrWData    = '0;
        oCsrRAddr    = '0;
        oPCRedirect  = 1'b0;
        oPCTarget    = '0;
        vecBase      = {iCsrRData[31:2], 2'b00};
        vecMode      = iCsrRData[1:0];
        vecOffset    = {25'b0, cause_q, 2'b00};

        unique case (state_q)
            IDLE: begin
                if (iExcValid) begin
                    oExcAck = 1'b1;
                    intr_d  = iExcIntr;
                    cause_d = iExcCause;
                    pc_d    = {iExcPC[31:2], 2'b00};
                    tval_d  = iExcTval;
                    state_d = W_EPC;
                end else if (iMret) begin
                    oMretAck = 1'b1;
                    state_d  = RD_EPC;
                end else begin
                    oCsrReqReady = 1'b1;
                    if (iCsrReqValid) begin
                        oCsrWe    = 1'b1;
                        oCsrWAddr = iCsrReqAddr;
                        oCsrWData = iCsrReqData;
                    end
                end
            end
            W_EPC: begin
                oCsrWe    = 1'b1;
                oCsrWAddr = MEPC_ADDR;
                oCsrWData = pc_q;
                state_d   = W_CAUSE;
            end
            W_CAUSE: begin
                oCsrWe    = 1'b1;
                oCsrWAddr = MCAUSE_ADDR;
                oCsrWData = {intr_q, 26'b0, cause_q};
                state_d   = W_TVAL;
            end
            W_TVAL: begin
                oCsrWe    = 1'b1;
                oCsrWAddr = MTVAL_ADDR;
                oCsrWData = tval_q;
                state_d   = RD_VEC;
            end
            RD_VEC: begin
                // Only interrupts are vectored; modes 2 and 3 fall back to direct.
                oCsrRAddr = MTVEC_ADDR;
                if (vecMode == 2'b01 && intr_q) begin
                    target_d = vecBase + vecOffset;
                end else begin
                    target_d = vecBase;
                end
                state_d = REDIR;
            end
            RD_EPC: begin
                oCsrRAddr = MEPC_ADDR;
                target_d  = {iCsrRData[31:2], 2'b00};
                state_d   = REDIR;
            end
            REDIR: begin
                oPCRedirect = 1'b1;
                oPCTarget   = target_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oStall = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a behavioural CSR file plus a scoreboard of expected
// CSR writes and fetch redirects, with cycle-accurate handshake and stall checks.
module tb_trap_sequencer;

    localparam logic [11:0] MTVEC  = 12'h305;
    localparam logic [11:0] MEPC   = 12'h341;
    localparam logic [11:0] MCAUSE = 12'h342;
    localparam logic [11:0] MTVAL  = 12'h343;

    logic        clk;
    logic        iRSTn;
    logic        iExcValid, iExcIntr, iMret, iCsrReqValid;
    logic [4:0]  iExcCause;
    logic [31:0] iExcPC, iExcTval, iCsrReqData, iCsrRData;
    logic [11:0] iCsrReqAddr;
    logic        oCsrReqReady, oExcAck, oMretAck, oCsrWe, oStall, oPCRedirect;
    logic [11:0] oCsrWAddr, oCsrRAddr;
    logic [31:0] oCsrWData, oPCTarget;

    typedef struct {
        logic        isRedir;
        logic [11:0] addr;
        logic [31:0] data;
    } expEvt_t;

    expEvt_t     expQ[$];
    expEvt_t     monEvt;
    int          compareCount;
    int          mismatchCount;

    logic [31:0] csrMem [0:4095];
    logic        tbWe;
    logic [11:0] tbAddr;
    logic [31:0] tbData;

    trap_sequencer dut (
        .iCLK         (clk),
        .iRSTn        (iRSTn),
        .iExcValid    (iExcValid),
        .iExcIntr     (iExcIntr),
        .iExcCause    (iExcCause),
        .iExcPC       (iExcPC),
        .iExcTval     (iExcTval),
        .iMret        (iMret),
        .iCsrReqValid (iCsrReqValid),
        .iCsrReqAddr  (iCsrReqAddr),
        .iCsrReqData  (iCsrReqData),
        .oCsrReqReady (oCsrReqReady),
        .oExcAck      (oExcAck),
        .oMretAck     (oMretAck),
        .oCsrWe       (oCsrWe),
        .oCsrWAddr    (oCsrWAddr),
        .oCsrWData    (oCsrWData),
        .oCsrRAddr    (oCsrRAddr),
        .iCsrRData    (iCsrRData),
        .oStall       (oStall),
        .oPCRedirect  (oPCRedirect),
        .oPCTarget    (oPCTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CSR file: one write port shared by the DUT and bench preloads, async read.
    always @(posedge clk) begin
        if (oCsrWe) csrMem[oCsrWAddr] <= oCsrWData;
        else if (tbWe) csrMem[tbAddr] <= tbData;
    end
    assign iCsrRData = csrMem[oCsrRAddr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every CSR write or redirect the DUT emits is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (oCsrWe || oPCRedirect) begin
            if (expQ.size() == 0) begin
                checkOutput("sbUnderflow", 32'(expQ.size()), 32'd1);
            end else begin
                monEvt = expQ.pop_front();
                checkOutput("evKind", 32'(oPCRedirect), 32'(monEvt.isRedir));
                checkOutput("weInRedir", 32'(oCsrWe & oPCRedirect), 32'd0);
                if (monEvt.isRedir) begin
                    checkOutput("target", oPCTarget, monEvt.data);
                end else begin
                    checkOutput("wAddr", 32'(oCsrWAddr), 32'(monEvt.addr));
                    checkOutput("wData", oCsrWData, monEvt.data);
                end
            end
        end
    end

    function automatic logic [31:0] expTarget(input logic [31:0] vec, input logic intr, input logic [4:0] cause);
        logic [31:0] base;
        base = vec & 32'hFFFF_FFFC;
        if (vec[1:0] == 2'b01 && intr) return base + 32'(cause) * 32'd4;
        return base;
    endfunction

    task automatic pushWrite(input logic [11:0] addr, input logic [31:0] data);
        expEvt_t e;
        e.isRedir = 1'b0;
        e.addr    = addr;
        e.data    = data;
        expQ.push_back(e);
    endtask

    task automatic pushRedir(input logic [31:0] target);
        expEvt_t e;
        e.isRedir = 1'b1;
        e.addr    = '0;
        e.data    = target;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preloadCsr(input logic [11:0] addr, input logic [31:0] data);
        tbWe   = 1'b1;
        tbAddr = addr;
        tbData = data;
        nextCycle();
        tbWe   = 1'b0;
    endtask

    task automatic applyStimulusTrap(input logic intr, input logic [4:0] cause, input logic [31:0] pc,
                                     input logic [31:0] tval, input logic [31:0] mtvec);
        preloadCsr(MTVEC, mtvec);
        iExcValid = 1'b1;
        iExcIntr  = intr;
        iExcCause = cause;
        iExcPC    = pc;
        iExcTval  = tval;
        pushWrite(MEPC, pc & 32'hFFFF_FFFC);
        pushWrite(MCAUSE, {intr, 26'b0, cause});
        pushWrite(MTVAL, tval);
        pushRedir(expTarget(mtvec, intr, cause));
        @(negedge clk);
        checkOutput("excAck", 32'(oExcAck), 32'd1);
        checkOutput("stallAccept", 32'(oStall), 32'd0);
        nextCycle();
        iExcValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("trapStall", 32'(oStall), 32'd1);
            checkOutput("trapWe", 32'(oCsrWe), 32'(k <= 3));
            checkOutput("trapRedir", 32'(oPCRedirect), 32'(k == 5));
            nextCycle();
        end
        @(negedge clk);
        checkOutput("trapDone", 32'(oStall), 32'd0);
        nextCycle();
    endtask

    task automatic applyStimulusMret(input logic [31:0] mepcVal);
        preloadCsr(MEPC, mepcVal);
        iMret = 1'b1;
        pushRedir(mepcVal & 32'hFFFF_FFFC);
        @(negedge clk);
        checkOutput("mretAck", 32'(oMretAck), 32'd1);
        checkOutput("mretStallN", 32'(oStall), 32'd0);
        nextCycle();
        iMret = 1'b0;
        @(negedge clk);
        checkOutput("mretStall1", 32'(oStall), 32'd1);
        checkOutput("mretRedir1", 32'(oPCRedirect), 32'd0);
        checkOutput("mretRAddr", 32'(oCsrRAddr), 32'(MEPC));
        nextCycle();
        @(negedge clk);
        checkOutput("mretStall2", 32'(oStall), 32'd1);
        checkOutput("mretRedir2", 32'(oPCRedirect), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("mretDone", 32'(oStall), 32'd0);
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        iRSTn = 1'b0;
        iExcValid = 1'b0; iExcIntr = 1'b0; iExcCause = '0; iExcPC = '0; iExcTval = '0;
        iMret = 1'b0; iCsrReqValid = 1'b0; iCsrReqAddr = '0; iCsrReqData = '0;
        tbWe = 1'b0; tbAddr = '0; tbData = '0;

        // Reset held for two cycles.
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rstStall", 32'(oStall), 32'd0);
        checkOutput("rstWe", 32'(oCsrWe), 32'd0);
        checkOutput("rstRedir", 32'(oPCRedirect), 32'd0);
        checkOutput("rstTarget", oPCTarget, 32'd0);
        checkOutput("rstRAddr", 32'(oCsrRAddr), 32'd0);
        checkOutput("rstReady", 32'(oCsrReqReady), 32'd1);
        nextCycle();
        iRSTn = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady", 32'(oCsrReqReady), 32'd1);
        checkOutput("postRstAck", 32'(oExcAck | oMretAck), 32'd0);
        nextCycle();

        $display("[TB] direct and vectored traps");
        applyStimulusTrap(1'b0, 5'd2,  32'h0000_0043, 32'hDEAD_BEEF, 32'h0000_0100);
        applyStimulusTrap(1'b1, 5'd7,  32'h0000_1000, 32'h0000_0000, 32'h0000_0201);
        applyStimulusTrap(1'b0, 5'd7,  32'h0000_1004, 32'h0000_0010, 32'h0000_0201);
        applyStimulusTrap(1'b1, 5'd3,  32'h0000_2002, 32'h1234_5678, 32'h0000_0303);
        applyStimulusTrap(1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        checkOutput("vecConst", expTarget(32'h0000_0201, 1'b1, 5'd7), 32'h0000_021C);

        $display("[TB] MRET");
        applyStimulusMret(32'h0000_1234);
        applyStimulusMret(32'h0000_1237);

        $display("[TB] CSR pass-through");
        iCsrReqValid = 1'b1;
        iCsrReqAddr  = 12'h300;
        iCsrReqData  = 32'h0000_0008;
        pushWrite(12'h300, 32'h0000_0008);
        @(negedge clk);
        checkOutput("ptReady", 32'(oCsrReqReady), 32'd1);
        checkOutput("ptWe", 32'(oCsrWe), 32'd1);
        checkOutput("ptStall", 32'(oStall), 32'd0);
        nextCycle();
        iCsrReqValid = 1'b0;

        $display("[TB] arbitration");
        preloadCsr(MTVEC, 32'h0000_0400);
        iExcValid = 1'b1; iExcIntr = 1'b0; iExcCause = 5'd11; iExcPC = 32'h0000_2006; iExcTval = 32'h0;
        iMret = 1'b1;
        iCsrReqValid = 1'b1; iCsrReqAddr = 12'h340; iCsrReqData = 32'h0000_00A5;
        pushWrite(MEPC, 32'h0000_2004);
        pushWrite(MCAUSE, 32'h0000_000B);
        pushWrite(MTVAL, 32'h0);
        pushRedir(32'h0000_0400);
        @(negedge clk);
        checkOutput("arbExcAck", 32'(oExcAck), 32'd1);
        checkOutput("arbMretAck", 32'(oMretAck), 32'd0);
        checkOutput("arbReady", 32'(oCsrReqReady), 32'd0);
        nextCycle();
        iExcValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("arbMretHeld", 32'(oMretAck), 32'd0);
            checkOutput("arbReadyHeld", 32'(oCsrReqReady), 32'd0);
            checkOutput("arbExcNoReAck", 32'(oExcAck), 32'd0);
            nextCycle();
        end
        pushRedir(32'h0000_2004);
        @(negedge clk);
        checkOutput("arbMretAck2", 32'(oMretAck), 32'd1);
        checkOutput("arbReady2", 32'(oCsrReqReady), 32'd0);
        checkOutput("arbWe2", 32'(oCsrWe), 32'd0);
        nextCycle();
        iMret = 1'b0;
        nextCycle();
        nextCycle();
        pushWrite(12'h340, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("arbReady3", 32'(oCsrReqReady), 32'd1);
        checkOutput("arbWe3", 32'(oCsrWe), 32'd1);
        nextCycle();
        iCsrReqValid = 1'b0;

        $display("[TB] reset mid-sequence");
        iExcValid = 1'b1; iExcIntr = 1'b0; iExcCause = 5'd4; iExcPC = 32'h0000_3000; iExcTval = 32'h0;
        pushWrite(MEPC, 32'h0000_3000);
        nextCycle();
        iExcValid = 1'b0;
        iRSTn = 1'b0;
        @(negedge clk);
        checkOutput("midStall", 32'(oStall), 32'd1);
        nextCycle();
        iRSTn = 1'b1;
        @(negedge clk);
        checkOutput("abortStall", 32'(oStall), 32'd0);
        checkOutput("abortReady", 32'(oCsrReqReady), 32'd1);
        checkOutput("abortWe", 32'(oCsrWe), 32'd0);
        nextCycle();
        nextCycle();

        checkOutput("sbDrain", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
